// File: rtl/buscador_sar_pkg.sv
// Shared types for the successive-approximation searcher: FSM states and
// the validity test for the comparator's three-flag code.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSCA = 2'd1,
        FIN   = 2'd2
    } estado_t;

    // Exactly one of igual/mayor/menor must be set for a trustworthy decision.
    function automatic logic flags_one_hot(input logic igual,
                                           input logic mayor,
                                           input logic menor);
        logic r;
        case ({igual, mayor, menor})
            3'b100, 3'b010, 3'b001: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/buscador_sar_if.sv
// Bus between the searcher and its environment: start request, comparator
// flags coming back, trial value going out, and the result/status outputs.
interface buscador_sar_if #(
    parameter int WIDTH = 8
);
    // inicio is a level request sampled only while the searcher is idle (no
    // back-pressure, not queued); listo is a single-cycle completion pulse
    // with resultado/err valid from that cycle until the next accepted inicio.
    logic             inicio;
    logic             igual_i;
    logic             mayor_i;
    logic             menor_i;
    logic [WIDTH-1:0] prueba;
    logic [WIDTH-1:0] resultado;
    logic             ocupado;
    logic             listo;
    logic             err;

    modport master (
        input  inicio, igual_i, mayor_i, menor_i,
        output prueba, resultado, ocupado, listo, err
    );

    modport slave (
        output inicio, igual_i, mayor_i, menor_i,
        input  prueba, resultado, ocupado, listo, err
    );
endinterface

// File: rtl/comparador8bits.sv
// 8-bit cascadable magnitude comparator; cascade inputs decide only when
// the local operands are equal.
module Comparador8bits (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_igual,
    input  logic       i_mayor,
    input  logic       i_menor,
    output logic       o_igual,
    output logic       o_mayor,
    output logic       o_menor
);
    always_comb begin
        o_igual = 1'b0;
        o_mayor = 1'b0;
        o_menor = 1'b0;
        if (i_a > i_b) begin
            o_mayor = 1'b1;
        end else if (i_a < i_b) begin
            o_menor = 1'b1;
        end else begin
            o_igual = i_igual;
            o_mayor = i_mayor;
            o_menor = i_menor;
        end
    end
endmodule

// File: rtl/buscador_sar.sv
// Successive-approximation searcher: resolves an unknown value one bit per
// clock, MSB first, using only an external comparator's igual/mayor/menor code.
module buscador_sar
    import sar_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    buscador_sar_if.master bus,
    output estado_t       o_estado
);
    localparam int               IW      = $clog2(WIDTH);
    localparam logic [IW-1:0]    IDX_MAX = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_UNO = IW'(1);
    localparam logic [WIDTH-1:0] UNO     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB     = UNO << (WIDTH - 1);

    estado_t          r_estado;
    logic [WIDTH-1:0] r_prueba;
    logic [WIDTH-1:0] r_resultado;
    logic [IW-1:0]    r_idx;
    logic             r_err;

    estado_t          w_estado_sig;
    logic [WIDTH-1:0] w_prueba_sig;
    logic [WIDTH-1:0] w_resultado_sig;
    logic [IW-1:0]    w_idx_sig;
    logic             w_err_sig;

    logic             w_flags_ok;
    logic [WIDTH-1:0] w_bit_idx;
    logic [WIDTH-1:0] w_bit_sig;
    logic [WIDTH-1:0] w_actualizado;

    assign w_flags_ok    = flags_one_hot(bus.igual_i, bus.mayor_i, bus.menor_i);
    assign w_bit_idx     = UNO << r_idx;
    assign w_bit_sig     = UNO << (r_idx - IDX_UNO);
    // a > prueba keeps the trial bit; a < prueba drops it. Only bit idx moves.
    assign w_actualizado = bus.mayor_i ? r_prueba : (r_prueba & ~w_bit_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= IDLE;
            r_prueba    <= '0;
            r_resultado <= '0;
            r_idx       <= IDX_MAX;
            r_err       <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_prueba    <= w_prueba_sig;
            r_resultado <= w_resultado_sig;
            r_idx       <= w_idx_sig;
            r_err       <= w_err_sig;
        end
    end

    always_comb begin
        w_estado_sig    = r_estado;
        w_prueba_sig    = r_prueba;
        w_resultado_sig = r_resultado;
        w_idx_sig       = r_idx;
        w_err_sig       = r_err;
        case (r_estado)
            IDLE: begin
                if (bus.inicio) begin
                    w_prueba_sig = MSB;
                    w_idx_sig    = IDX_MAX;
                    w_err_sig    = 1'b0;
                    w_estado_sig = BUSCA;
                end
            end
            BUSCA: begin
                if (!w_flags_ok) begin
                    w_err_sig       = 1'b1;
                    w_resultado_sig = r_prueba;
                    w_estado_sig    = FIN;
                end else if (bus.igual_i) begin
                    // Bits below idx are still zero, so the trial is the answer.
                    w_resultado_sig = r_prueba;
                    w_estado_sig    = FIN;
                end else if (r_idx == '0) begin
                    w_resultado_sig = w_actualizado;
                    w_prueba_sig    = w_actualizado;
                    w_estado_sig    = FIN;
                end else begin
                    w_idx_sig    = r_idx - IDX_UNO;
                    w_prueba_sig = w_actualizado | w_bit_sig;
                end
            end
            FIN: begin
                w_prueba_sig = r_resultado;
                w_estado_sig = IDLE;
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    assign bus.prueba    = r_prueba;
    assign bus.resultado = r_resultado;
    assign bus.ocupado   = (r_estado == BUSCA);
    assign bus.listo     = (r_estado == FIN);
    assign bus.err       = r_err;
    assign o_estado      = r_estado;

endmodule

// File: tb/tb_buscador_sar.sv
// Bench for buscador_sar against an 8-bit comparator and a target register:
// a vector table of searches plus hand-written reset/back-to-back sequences.
module tb_buscador_sar;
    import sar_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] objetivo;
    logic       forzar_flags;
    logic       mantener;
    logic       c_igual, c_mayor, c_menor;
    estado_t    estado;

    int n_checks = 0;
    int n_errors = 0;
    int n_igual;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] objetivo;
        int         forzar;
        logic [7:0] exp_res;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t tabla[10];

    buscador_sar_if #(.WIDTH(8)) bus ();

    buscador_sar #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .o_estado (estado)
    );

    Comparador8bits u_cmp (
        .i_a     (objetivo),
        .i_b     (bus.prueba),
        .i_igual (1'b1),
        .i_mayor (1'b0),
        .i_menor (1'b0),
        .o_igual (c_igual),
        .o_mayor (c_mayor),
        .o_menor (c_menor)
    );

    assign bus.igual_i = forzar_flags ? 1'b0 : c_igual;
    assign bus.mayor_i = forzar_flags ? 1'b0 : c_mayor;
    assign bus.menor_i = forzar_flags ? 1'b0 : c_menor;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nombre, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", nombre, got, exp);
        end
    endtask

    // Pulse inicio so it is sampled at edge E0; returns 1 time unit after E0.
    task automatic iniciar();
        @(negedge clk);
        bus.inicio = 1'b1;
        @(posedge clk);
        #1;
        if (!mantener) bus.inicio = 1'b0;
    endtask

    // Called 1 unit after E0. Walks cycles until listo, recording trials.
    task automatic esperar_listo(input int forzar, input int pulso_k,
                                 output int lat, output int busy);
        int k;
        lat = -1;
        busy = 0;
        k = 0;
        n_igual = 0;
        got_q.delete();
        while (k < 40) begin
            forzar_flags = bus.ocupado && (k + 1 == forzar);
            #0;
            if (bus.ocupado) begin
                busy++;
                got_q.push_back(bus.prueba);
                if (bus.igual_i) n_igual++;
            end
            if (bus.listo) begin
                lat = k;
                break;
            end
            bus.inicio = mantener || (k == pulso_k);
            @(posedge clk);
            #1;
            k++;
        end
        forzar_flags = 1'b0;
        if (!mantener) bus.inicio = 1'b0;
        check("listo_timeout", (lat < 0) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic comparar_trials(input string nombre);
        check({nombre, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(nombre, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
    endtask

    initial begin
        int lat, busy;
        rst_n        = 1'b0;
        bus.inicio   = 1'b0;
        objetivo     = 8'h00;
        forzar_flags = 1'b0;
        mantener     = 1'b0;

        tabla[0] = '{8'hA5, 0, 8'hA5, 1'b0, 8};
        tabla[1] = '{8'h80, 0, 8'h80, 1'b0, 1};
        tabla[2] = '{8'h00, 0, 8'h00, 1'b0, 8};
        tabla[3] = '{8'hFF, 0, 8'hFF, 1'b0, 8};
        tabla[4] = '{8'hA5, 3, 8'hA0, 1'b1, 3};
        tabla[5] = '{8'hA5, 0, 8'hA5, 1'b0, 8};
        tabla[6] = '{8'h40, 0, 8'h40, 1'b0, 2};
        tabla[7] = '{8'hC0, 0, 8'hC0, 1'b0, 2};
        tabla[8] = '{8'h55, 0, 8'h55, 1'b0, 8};
        tabla[9] = '{8'h01, 0, 8'h01, 1'b0, 8};

        #12;
        check("rst_prueba", 32'(bus.prueba), 32'h0);
        check("rst_resultado", 32'(bus.resultado), 32'h0);
        check("rst_ocupado", 32'(bus.ocupado), 32'h0);
        check("rst_listo", 32'(bus.listo), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_estado", 32'(estado), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            objetivo = tabla[i].objetivo;
            if (i == 4) check("err_sticky_before", 32'(bus.err), 32'h0);
            if (i == 5) check("err_sticky_idle", 32'(bus.err), 32'h1);
            if (i == 0) exp_q = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
            if (i == 2) exp_q = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
            if (i == 3) exp_q = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
            iniciar();
            if (i == 5) check("err_cleared_on_start", 32'(bus.err), 32'h0);
            esperar_listo(tabla[i].forzar, -1, lat, busy);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(tabla[i].exp_lat));
            check($sformatf("v%0d_ocupado_cycles", i), 32'(busy), 32'(tabla[i].exp_lat));
            check($sformatf("v%0d_resultado", i), 32'(bus.resultado), 32'(tabla[i].exp_res));
            check($sformatf("v%0d_err", i), 32'(bus.err), 32'(tabla[i].exp_err));
            check($sformatf("v%0d_prueba_fin", i), 32'(bus.prueba), 32'(tabla[i].exp_res));
            if (i == 0) comparar_trials("trials_a5");
            if (i == 2) begin
                comparar_trials("trials_00");
                check("v2_no_igual", 32'(n_igual), 32'h0);
            end
            if (i == 3) comparar_trials("trials_ff");
            @(posedge clk);
            #1;
            check($sformatf("v%0d_listo_one_cycle", i), 32'(bus.listo), 32'h0);
            check($sformatf("v%0d_back_idle", i), 32'(estado), 32'(IDLE));
            check($sformatf("v%0d_resultado_stable", i), 32'(bus.resultado), 32'(tabla[i].exp_res));
            check($sformatf("v%0d_err_hold", i), 32'(bus.err), 32'(tabla[i].exp_err));
            check($sformatf("v%0d_prueba_idle", i), 32'(bus.prueba), 32'(tabla[i].exp_res));
        end

        // back-to-back with inicio held high
        mantener = 1'b1;
        objetivo = 8'hFF;
        iniciar();
        esperar_listo(0, -1, lat, busy);
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_resultado", 32'(bus.resultado), 32'hFF);
        objetivo = 8'h7F;
        @(posedge clk);
        #1;
        check("b2b_idle_estado", 32'(estado), 32'(IDLE));
        check("b2b_idle_prueba", 32'(bus.prueba), 32'hFF);
        @(posedge clk);
        #1;
        check("b2b_restart_ocupado", 32'(bus.ocupado), 32'h1);
        check("b2b_restart_prueba", 32'(bus.prueba), 32'h80);
        mantener = 1'b0;
        bus.inicio = 1'b0;
        esperar_listo(0, -1, lat, busy);
        check("b2b_second_latency", 32'(lat), 32'd8);
        check("b2b_second_resultado", 32'(bus.resultado), 32'h7F);
        repeat (2) @(posedge clk);

        // asynchronous reset during the 4th BUSCA cycle
        objetivo = 8'hA5;
        iniciar();
        repeat (3) @(posedge clk);
        #2;
        check("abort_pre_prueba", 32'(bus.prueba), 32'hB0);
        rst_n = 1'b0;
        #1;
        check("abort_prueba", 32'(bus.prueba), 32'h0);
        check("abort_resultado", 32'(bus.resultado), 32'h0);
        check("abort_ocupado", 32'(bus.ocupado), 32'h0);
        check("abort_listo", 32'(bus.listo), 32'h0);
        check("abort_err", 32'(bus.err), 32'h0);
        check("abort_estado", 32'(estado), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("abort_no_listo", 32'(bus.listo), 32'h0);
        end
        check("abort_stays_idle", 32'(estado), 32'(IDLE));

        // inicio pulsed during BUSCA is ignored and not queued
        objetivo = 8'h10;
        iniciar();
        esperar_listo(0, 2, lat, busy);
        check("ignore_latency", 32'(lat), 32'd4);
        check("ignore_resultado", 32'(bus.resultado), 32'h10);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("ignore_not_queued", 32'(bus.ocupado), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
